// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - Moore serial pattern detector with KMP transition table and saturating match counter
// Transition table is built at elaboration; the datapath only looks up (state, x_in).
module moore_seq_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                ST_W    = $clog2(PAT_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_in,
  input  logic             en,
  output logic             y_out,
  output logic [ST_W-1:0]  state,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  typedef logic [2*(PAT_LEN+1)-1:0][ST_W-1:0] trans_t;

  // Bit j of the pattern in reception order (j = 0 is the first bit received).
  function automatic bit pat_bit(input int j);
    logic [PAT_LEN-1:0] v_sh;
    v_sh = PATTERN >> (PAT_LEN - 1 - j);
    return v_sh[0];
  endfunction

  // Longest proper border of the full pattern.
  function automatic int pat_border();
    int  v_best;
    bit  v_ok;
    v_best = 0;
    for (int k = PAT_LEN - 1; k > 0; k--) begin
      v_ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (pat_bit(j) != pat_bit(PAT_LEN - k + j)) v_ok = 1'b0;
      end
      if (v_ok && (v_best == 0)) v_best = k;
    end
    return v_best;
  endfunction

  // Longest pattern prefix that is a suffix of (matched prefix of length s, b).
  function automatic int step_state(input int s, input bit b);
    int v_start;
    int v_res;
    int v_pos;
    bit v_ok;
    bit v_tb;
    v_start = s;
    if (s == PAT_LEN) v_start = OVERLAP ? pat_border() : 0;
    v_res = 0;
    for (int k = v_start + 1; k > 0; k--) begin
      v_ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        v_pos = v_start + 1 - k + j;
        v_tb  = (v_pos == v_start) ? b : pat_bit(v_pos);
        if (v_tb != pat_bit(j)) v_ok = 1'b0;
      end
      if (v_ok && (v_res == 0)) v_res = k;
    end
    return v_res;
  endfunction

  // Entry {s, b} holds the successor of state s on input bit b.
  function automatic trans_t build_trans();
    trans_t          v_tab;
    logic [ST_W-1:0] v_nxt;
    v_tab = '0;
    for (int s = PAT_LEN; s >= 0; s--) begin
      for (int b = 1; b >= 0; b--) begin
        v_nxt = ST_W'(step_state(s, b[0]));
        v_tab = (v_tab << ST_W) | trans_t'(v_nxt);
      end
    end
    return v_tab;
  endfunction

  localparam trans_t          TRANS   = build_trans();
  localparam logic [ST_W-1:0] S_MATCH = ST_W'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);

  logic [ST_W-1:0]  r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic [ST_W:0]    w_idx;
  logic [ST_W-1:0]  w_next;
  logic             w_hit;

  always_comb begin
    w_idx  = {r_state, x_in};
    w_next = TRANS[w_idx];
    w_hit  = (w_next == S_MATCH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (en) begin
      r_state <= w_next;
      if (w_hit && !r_sat) begin
        r_count <= r_count + CNT_W'(1);
        if (r_count == CNT_PRE) r_sat <= 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign y_out       = (r_state == S_MATCH);
  assign match_count = r_count;
  assign count_sat   = r_sat;

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-type serial sequence detector. It samples a single-bit serial input on each enabled clock edge and asserts a registered output while a programmable bit pattern has just been completed. Overlapping or non-overlapping matching is selectable, and it keeps a saturating match counter. It generalises the fixed-pattern Moore detector exercises into a reusable block for serial-protocol front ends in the sequential design set.

## Interface
- `PAT_LEN`, 4: pattern length in bits, 1..16.
- `PATTERN`, 4'b1011: pattern value, `PAT_LEN` bits wide; bit `PAT_LEN-1` is the first bit received.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = the detector restarts after each match.
- `CNT_W`, 8: width of the match counter.
- Derived `ST_W` = `$clog2(PAT_LEN+1)`.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `x_in` in 1: serial data bit, sampled only when `en`=1.
- `en` in 1: sample enable; when 0, all state is held.
- `y_out` out 1: Moore match output; high iff state == `PAT_LEN`.
- `state` out `ST_W`: current state, equal to the number of pattern bits currently matched.
- `match_count` out `CNT_W`: number of matches since reset; saturates.
- `count_sat` out 1: high once `match_count` has reached all-ones.

## Operation
- **States** S0..S`PAT_LEN`. Si means the last i sampled bits equal the first i pattern bits. S`PAT_LEN` is the match state.
- **Next state.** On a rising edge with `en`=1, the next state is the longest prefix of the pattern that is a suffix of (matched prefix, `x_in`), i.e. KMP failure-function semantics.
  - The transition table is computed at elaboration by a constant function. No runtime pattern storage is used.
- **From S`PAT_LEN`:**
  - `OVERLAP`=1: continue from the longest proper border of the pattern, then apply `x_in`.
  - `OVERLAP`=0: continue from S0, then apply `x_in`. A bit equal to `PATTERN[PAT_LEN-1]` therefore moves to S1.
- **`y_out`** is a pure decode of the state register (Moore). `x_in` has no combinational path to any output.
- **`match_count`** increments by 1 on each edge where the next state is S`PAT_LEN` and `en`=1.
  - It holds at 2^`CNT_W`-1. It never wraps.
  - `count_sat` is registered and is set in the same cycle the counter reaches all-ones.
- **`en`=0:** state, `y_out`, `match_count` and `count_sat` all hold.
- **`reset`=1 at an edge:** state=S0, `y_out`=0, `match_count`=0, `count_sat`=0, regardless of `en` or `x_in`. Reset overrides any in-progress partial match.
- **`PAT_LEN`=1:** the block degenerates to "`y_out`=1 the cycle after `x_in`==`PATTERN[0]`". Both `OVERLAP` settings then behave identically.

## Timing
- Latency: the final pattern bit is sampled at edge k; `y_out` is high from edge k until edge k+1.
  - With `OVERLAP`=1 and back-to-back matches, it stays high across consecutive cycles.
- `y_out` width is exactly one enabled sample period per match. If `en` drops while in the match state, `y_out` stays high until the next enabled edge or reset.
- `match_count` updates on the same edge `y_out` rises.
- Reset mid-pattern: the cycle after reset, state=0. A match requires a full `PAT_LEN` fresh bits after reset deasserts.
- All outputs are registered or decoded from registers; no outputs are valid before the first reset.

## Test plan
- **Reset.** Assert `reset` 2 cycles with `x_in` toggling -> `state`=0, `y_out`=0, `match_count`=0, `count_sat`=0. De-assert `reset`, hold `en`=0 for 5 cycles -> all outputs unchanged.
- **Overlap.** `PATTERN`=4'b1011, `OVERLAP`=1, `en`=1, `x_in`=1,0,1,1,0,1,1 -> `y_out` high after the 4th and 7th bits; `match_count`=2. The state sequence is 1,2,3,4,2,3,4.
- **Non-overlap.** Same stream with `OVERLAP`=0 -> `y_out` high only after the 4th bit; `match_count`=1. The state sequence is 1,2,3,4,0,1,1.
- **Enable gaps.** Stream 1,0,1,1 with `en`=0 for 3 cycles between each bit -> exactly one match. `y_out` rises on the edge that samples the 4th bit and holds through the following `en`=0 cycles.
- **Reset mid-operation.** Send 1,0,1, assert `reset` for one edge, then send 1 -> no match; `state`=1. Then send 0,1,1 -> match; `match_count`=1.
- **Saturation.** `CNT_W`=2, `PATTERN`=1'b1, `PAT_LEN`=1, `x_in`=1 for 6 cycles -> `match_count` goes 1,2,3,3,3,3; `count_sat` rises with the 3rd match and stays high until `reset`.
